// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Collects one partial sum from each of NUM_PSUM PE rows (sources
//   0..NUM_PSUM-1, any arrival order) for the current output location.
//   It adds them and emits one OFM packet per completed location.
//   Filter echo packets (type bit = 0) are counted and discarded.
//
// Packet layout: [46] type (1 = psum, 0 = filter), [45:43] dest,
//                [42:40] src, [39:0] data.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready     packet input from the PE network
//   out_data/out_valid/out_ready  OFM packet toward the memory node
//   err_dup          1-cycle pulse: repeated src in current location (dropped)
//   err_src          1-cycle pulse: src >= NUM_PSUM (dropped)
//   filt_drop_cnt    discarded filter packets, wraps at 2^16
//   ofm_cnt          emitted output packets, wraps at 2^16
//
// Optional build macro: PSUM_SAT_EN
//   When defined, the emitted sum is clamped to 2^DWIDTH-1.
//   When undefined, the full ACC_W-bit sum is emitted, zero-extended to 40 bits.
module psum_accumulator #(
  parameter int         DWIDTH   = 8,
  parameter int         PWIDTH   = 47,
  parameter int         NUM_PSUM = 3,
  parameter logic [2:0] MY_ADDR  = 3'b111,
  parameter logic [2:0] OUT_ADDR = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_dup,
  output logic              err_src,
  output logic [15:0]       filt_drop_cnt,
  output logic [15:0]       ofm_cnt
);

  // At least one guard bit, so NUM_PSUM = 1 still gets DWIDTH+1 bits.
  localparam int ACC_W = DWIDTH + ((NUM_PSUM > 1) ? $clog2(NUM_PSUM) : 1);
  localparam logic [NUM_PSUM-1:0] ALL_SEEN = '1;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [NUM_PSUM-1:0] seen_q, seen_d;
  logic [PWIDTH-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                err_dup_q, err_dup_d;
  logic                err_src_q, err_src_d;
  logic [15:0]         filt_cnt_q, filt_cnt_d;
  logic [15:0]         ofm_cnt_q, ofm_cnt_d;

  logic                pkt_type;
  logic [2:0]          pkt_src;
  logic [ACC_W-1:0]    psum_ext;
  logic [ACC_W-1:0]    acc_next;
  logic [7:0]          seen_ext;
  logic [7:0]          src_onehot;
  logic [NUM_PSUM-1:0] seen_set;
  logic                src_bad;
  logic                unused_in_bits;

  // The dest field and the data bits above the psum carry nothing for this block.
  assign unused_in_bits = ^{in_data[45:43], in_data[39:DWIDTH]};

  // Format the final sum into the 40-bit data field.
  function automatic logic [39:0] fmt_sum(input logic [ACC_W-1:0] sum);
    logic [39:0] r;
    r = '0;
`ifdef PSUM_SAT_EN
    if (|sum[ACC_W-1:DWIDTH]) r[DWIDTH-1:0] = '1;
    else                      r[DWIDTH-1:0] = sum[DWIDTH-1:0];
`else
    r[ACC_W-1:0] = sum;
`endif
    return r;
  endfunction

  assign pkt_type   = in_data[46];
  assign pkt_src    = in_data[42:40];
  assign psum_ext   = ACC_W'(in_data[DWIDTH-1:0]);
  assign acc_next   = acc_q + psum_ext;
  // Pad the mask to the full 3-bit src range so an out-of-range src never indexes past it.
  assign seen_ext   = 8'(seen_q);
  assign src_onehot = 8'd1 << pkt_src;
  assign seen_set   = seen_q | src_onehot[NUM_PSUM-1:0];
  assign src_bad    = ({1'b0, pkt_src} >= 4'(NUM_PSUM));

  assign in_ready = (state_q == ACCUM);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    seen_d      = seen_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_dup_d   = 1'b0;
    err_src_d   = 1'b0;
    filt_cnt_d  = filt_cnt_q;
    ofm_cnt_d   = ofm_cnt_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (!pkt_type) begin
            filt_cnt_d = filt_cnt_q + 16'd1;
          end else if (src_bad) begin
            err_src_d = 1'b1;
          end else if (seen_ext[pkt_src]) begin
            err_dup_d = 1'b1;
          end else begin
            acc_d  = acc_next;
            seen_d = seen_set;
            // Last psum of the location: load the output on this same edge.
            if (seen_set == ALL_SEEN) begin
              state_d     = EMIT;
              out_valid_d = 1'b1;
              out_data_d  = {1'b1, OUT_ADDR, MY_ADDR, fmt_sum(acc_next)};
            end
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d     = ACCUM;
          acc_d       = '0;
          seen_d      = '0;
          out_valid_d = 1'b0;
          ofm_cnt_d   = ofm_cnt_q + 16'd1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      seen_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_dup_q   <= 1'b0;
      err_src_q   <= 1'b0;
      filt_cnt_q  <= '0;
      ofm_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      seen_q      <= seen_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_dup_q   <= err_dup_d;
      err_src_q   <= err_src_d;
      filt_cnt_q  <= filt_cnt_d;
      ofm_cnt_q   <= ofm_cnt_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign err_dup       = err_dup_q;
  assign err_src       = err_src_q;
  assign filt_drop_cnt = filt_cnt_q;
  assign ofm_cnt       = ofm_cnt_q;

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [46:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [46:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_dup, err_src;
  logic [15:0] filt_drop_cnt, ofm_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: a set of sources seen so far, their running total,
  // and a pending output packet awaiting acceptance.
  bit          m_pending;
  bit [46:0]   m_out;
  int          m_sum;
  bit          m_seen[8];
  int          m_filt, m_ofm;
  bit          m_edup, m_esrc;

  psum_accumulator #(.DWIDTH(8), .PWIDTH(47), .NUM_PSUM(N),
                     .MY_ADDR(3'b111), .OUT_ADDR(3'b000)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_dup(err_dup), .err_src(err_src),
    .filt_drop_cnt(filt_drop_cnt), .ofm_cnt(ofm_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit [46:0] pkt(input bit typ, input bit [2:0] src, input bit [39:0] data);
    return {typ, 3'(($urandom) & 7), src, data};
  endfunction

  function automatic bit [46:0] exp_pkt(input int sum);
    bit [39:0] d;
`ifdef PSUM_SAT_EN
    d = (sum > 255) ? 40'd255 : 40'(sum);
`else
    d = 40'(sum);
`endif
    return {1'b1, 3'b000, 3'b111, d};
  endfunction

  function automatic bit all_seen();
    for (int i = 0; i < N; i++) if (!m_seen[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_sum = 0;
    for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
  endtask

  // Apply the behaviour rules for one clock edge using the inputs held across it.
  task automatic model_edge();
    int src;
    if (rst) begin
      m_pending = 0; m_out = '0; m_filt = 0; m_ofm = 0; m_edup = 0; m_esrc = 0;
      model_clear();
      return;
    end
    m_edup = 0; m_esrc = 0;
    if (m_pending) begin
      if (out_ready) begin
        m_pending = 0; m_ofm = (m_ofm + 1) % 65536;
        model_clear();
      end
    end else if (in_valid) begin
      src = int'(in_data[42:40]);
      if (!in_data[46])      m_filt = (m_filt + 1) % 65536;
      else if (src >= N)     m_esrc = 1;
      else if (m_seen[src])  m_edup = 1;
      else begin
        m_sum += int'(in_data[7:0]);
        m_seen[src] = 1;
        if (all_seen()) begin
          m_pending = 1;
          m_out = exp_pkt(m_sum);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [46:0] d, input logic ordy);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    @(negedge clk);
    check("in_ready", in_ready, !m_pending);
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", out_valid, m_pending);
    if (m_pending) check("out_data", out_data, m_out);
    check("err_dup", err_dup, m_edup);
    check("err_src", err_src, m_esrc);
    check("filt_cnt", filt_drop_cnt, m_filt);
    check("ofm_cnt", ofm_cnt, m_ofm);
  endtask

  task automatic psum(input bit [2:0] src, input bit [39:0] val, input logic ordy);
    step(1'b0, 1'b1, pkt(1'b1, src, val), ordy);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, '0, ordy);
  endtask

  initial begin
    bit [46:0] held;
    // Reset
    step(1'b1, 1'b0, '0, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 47'd0);
    check("rst_ofm", ofm_cnt, 16'd0);

    // Basic sum 5+9+2, output one cycle after the last accept
    psum(3'd0, 40'd5, 1'b0);
    psum(3'd1, 40'd9, 1'b0);
    check("t1_pre_valid", out_valid, 1'b0);
    psum(3'd2, 40'd2, 1'b0);
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, {1'b1, 3'b000, 3'b111, 40'd16});
    check("t1_in_ready", in_ready, 1'b0);
    idle(1'b1);
    check("t1_ofm", ofm_cnt, 16'd1);
    check("t1_back_ready", in_ready, 1'b1);

    // Large psums: 600 or clamped to 255
    psum(3'd2, 40'd200, 1'b0);
    psum(3'd0, 40'd200, 1'b0);
    psum(3'd1, 40'd200, 1'b0);
`ifdef PSUM_SAT_EN
    check("t2_sat", out_data[39:0], 40'd255);
`else
    check("t2_full", out_data[39:0], 40'h258);
`endif
    idle(1'b1);

    // Filter interleaved between psums
    psum(3'd0, 40'd10, 1'b0);
    step(1'b0, 1'b1, {1'b0, 3'b011, 3'b110, 40'h5}, 1'b0);
    check("t3_filt", filt_drop_cnt, 16'd1);
    psum(3'd1, 40'd20, 1'b0);
    psum(3'd2, 40'd30, 1'b0);
    check("t3_sum", out_data[39:0], 40'd60);
    idle(1'b1);

    // Duplicate source
    psum(3'd1, 40'd7, 1'b0);
    psum(3'd1, 40'd4, 1'b0);
    check("t4_dup_pulse", err_dup, 1'b1);
    psum(3'd0, 40'd1, 1'b0);
    check("t4_dup_clear", err_dup, 1'b0);
    psum(3'd2, 40'd1, 1'b0);
    check("t4_sum", out_data[39:0], 40'd9);
    idle(1'b1);

    // Out-of-range source
    psum(3'd5, 40'd50, 1'b0);
    check("t5_src_pulse", err_src, 1'b1);
    idle(1'b0);
    check("t5_src_clear", err_src, 1'b0);
    check("t5_no_out", out_valid, 1'b0);

    // Backpressure, then reset while output is pending
    psum(3'd0, 40'd3, 1'b0);
    psum(3'd1, 40'd4, 1'b0);
    psum(3'd2, 40'd5, 1'b0);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, pkt(1'b1, 3'd0, 40'd99), 1'b0);
      check("t6_stable", out_data, held);
    end
    step(1'b1, 1'b0, '0, 1'b1);
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_filt", filt_drop_cnt, 16'd0);
    check("t6_rst_ofm", ofm_cnt, 16'd0);
    psum(3'd2, 40'd11, 1'b0);
    psum(3'd0, 40'd22, 1'b0);
    psum(3'd1, 40'd33, 1'b1);
    check("t6_fresh_sum", out_data[39:0], 40'd66);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit [2:0]  s;
      bit        t;
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      t = ($urandom_range(0, 7) != 0);
      step(($urandom_range(0, 299) == 0), 1'($urandom), pkt(t, s, 40'($urandom) | (40'($urandom) << 32)),
           1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of a row of PE wrappers and consumes their 47-bit result packets.
- Collects one partial sum per PE row for the current output location and adds them.
- Emits one output-feature-map packet per completed location toward the OFM/memory node.
- Filter echo packets (type bit = 0) are counted and discarded.

Parameters:
- DWIDTH, 8, width of one data element / psum.
- PWIDTH, 47, packet width: [46] type (1 = pixel/psum, 0 = filter), [45:43] dest, [42:40] src, [39:0] data.
- NUM_PSUM, 3, psums per output location; sources 0..NUM_PSUM-1; legal range 1..8.
- MY_ADDR, 3'b111, value placed in the src field of output packets.
- OUT_ADDR, 3'b000, value placed in the dest field of output packets.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  PWIDTH  incoming packet from the PE network.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  PWIDTH  output OFM packet.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- err_dup  output  1  one-cycle pulse: duplicate src within the current location; packet dropped.
- err_src  output  1  one-cycle pulse: src >= NUM_PSUM; packet dropped.
- filt_drop_cnt  output  16  count of discarded filter packets, wraps at 2^16.
- ofm_cnt  output  16  count of emitted output packets, wraps at 2^16.

Behaviour:
- Reset (clk edge with rst = 1): state ACCUM, accumulator 0, seen-mask 0, out_valid 0, out_data 0, err pulses 0, both counters 0. Reset overrides any handshake in progress; a pending output is discarded.
- ACC_W = DWIDTH + $clog2(NUM_PSUM), minimum DWIDTH + 1. Psums are unsigned in_data[DWIDTH-1:0]; the sum is exact in ACC_W bits.
- Input transfer occurs when in_valid && in_ready on the clock edge.
- in_ready = 1 in ACCUM and 0 in EMIT. in_ready is combinational on state only, not on in_valid.
- ACCUM state, on a transfer:
  - type = 0: filt_drop_cnt++, no other effect.
  - type = 1, src >= NUM_PSUM: err_src pulses next cycle; packet dropped.
  - type = 1, seen[src] = 1: err_dup pulses next cycle; packet dropped.
  - Otherwise: acc += psum and seen[src] set.
  - When the mask becomes all-ones, go to EMIT on the same edge. out_data and out_valid are registered, so out_valid rises the cycle after the last psum is accepted (latency 1).
- EMIT state:
  - out_data = {1'b1, OUT_ADDR, MY_ADDR, zero-extended final sum in [39:0]}.
  - out_valid stays 1 and out_data stays stable until out_ready.
  - On out_valid && out_ready: ofm_cnt++, acc = 0, seen = 0, out_valid = 0, return to ACCUM. The next input is accepted on the following cycle at the earliest.
- Arrival order of srcs is arbitrary. The dest field of incoming packets is ignored.
- NUM_PSUM = 1: every valid psum produces an output packet.

Optional Feature:
- Macro: PSUM_SAT_EN.
- Defined: the output sum is clamped to 2^DWIDTH - 1 and placed in data[DWIDTH-1:0]; data[39:DWIDTH] = 0.
- Undefined: the full ACC_W-bit sum is emitted, zero-extended to 40 bits.
- The accumulator is ACC_W bits in both builds.

Test Plan:
- Reset, then psums 5 (src0), 9 (src1), 2 (src2), out_ready = 1 -> out_valid one cycle after the 3rd accept; out_data = {1, 000, 111, 40'd16}; ofm_cnt = 1; in_ready = 0 while out_valid = 1.
- Psums 200, 200, 200 -> sum 600 (0x258) without PSUM_SAT_EN; data = 255 with PSUM_SAT_EN.
- Filter packet {0, 011, 110, 0, 0, 1, 0, 1} interleaved between psums -> filt_drop_cnt = 1; the sum is unaffected.
- Src1 sent twice (7, then 4), then src0 = 1, src2 = 1 -> err_dup single-cycle pulse; output sum = 9.
- Src = 5 with NUM_PSUM = 3 -> err_src pulse; no accumulation; no output.
- Hold out_ready = 0 for 10 cycles in EMIT -> out_data stable and in_ready = 0; then assert rst -> out_valid = 0 and counters = 0 the next cycle; a fresh 3-psum set then sums correctly.
